// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the cpu stage:
// assembler byte-index states, the default NOP word and tensor opcodes.
package fetch_pkg;

  // Which byte of the 32-bit word the assembler expects next (MSB first).
  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } byte_idx_e;

  // Word issued to the cpu whenever nothing real is available.
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Opcodes (byte 3 of a word) shared with the cpu decoder.
  localparam logic [7:0] OP_TENSOR_BULK     = 8'h05;
  localparam logic [7:0] OP_TENSOR_LOAD_IMM = 8'h06;

  // Next assembler state after a byte has been taken.
  function automatic byte_idx_e next_byte_idx(input byte_idx_e idx);
    case (idx)
      BYTE0:   return BYTE1;
      BYTE1:   return BYTE2;
      BYTE2:   return BYTE3;
      default: return BYTE0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Small synchronous FIFO of assembled instruction words. Occupancy is held
// in its own counter so full and empty never alias; read/write pointers
// wrap naturally because DEPTH is a power of two. Flush wins over push/pop.
module instruction_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage write: data only, the pointers and count decide what is valid.
  // NOTE: the storage array is deliberately not reset; a reset loop over the
  // array would cost a reset net per bit and the count already masks stale data.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: assembles a byte-serial stream (MSB first) into
// 32-bit words, buffers them in instruction_fifo and issues one registered
// word per clock to the cpu, substituting NOP when nothing can be issued.
// Optional build macro FETCH_ISSUE_COUNTER_EN adds issue_count_out, a 16-bit
// wrapping count of issued (valid) words, cleared by reset and flush.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] NOP_INSTRUCTION = NOP_DEFAULT,
  localparam int         CW              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock_in,
  input  logic          reset_in,
  input  logic          byte_valid_in,
  input  logic [7:0]    byte_data_in,
  output logic          byte_ready_out,
  input  logic          stall_in,
  input  logic          flush_in,
  output logic [31:0]   current_instruction_out,
  output logic          instruction_valid_out,
  output logic [CW-1:0] fifo_count_out
`ifdef FETCH_ISSUE_COUNTER_EN
  ,
  output logic [15:0]   issue_count_out
`endif
);

  byte_idx_e   byte_idx;
  logic [23:0] partial;
  logic        byte_xfer;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic [31:0] push_word;

  // Handshake and FIFO control; flush blocks intake and pre-empts any pop.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    byte_ready_out = 1'b0;
    byte_xfer      = 1'b0;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    push_word      = {partial, byte_data_in};
    byte_ready_out = !fifo_full && !flush_in;
    byte_xfer      = byte_valid_in && byte_ready_out;
    fifo_push      = byte_xfer && (byte_idx == BYTE3);
    fifo_pop       = !flush_in && !stall_in && !fifo_empty;
  end

  instruction_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clock_in),
    .rst_n     (reset_in),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .flush     (flush_in),
    .head_data (fifo_head),
    .count     (fifo_count_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Byte assembler: shift accepted bytes into the partial word, advance index.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      byte_idx <= BYTE0;
      partial  <= '0;
    end else if (flush_in) begin
      byte_idx <= BYTE0;
      partial  <= '0;
    end else if (byte_xfer) begin
      byte_idx <= next_byte_idx(byte_idx);
      partial  <= {partial[15:0], byte_data_in};
    end
  end

  // Issue stage: present the popped head for exactly one cycle, else NOP.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      current_instruction_out <= NOP_INSTRUCTION;
      instruction_valid_out   <= 1'b0;
    end else if (fifo_pop) begin
      current_instruction_out <= fifo_head;
      instruction_valid_out   <= 1'b1;
    end else begin
      current_instruction_out <= NOP_INSTRUCTION;
      instruction_valid_out   <= 1'b0;
    end
  end

`ifdef FETCH_ISSUE_COUNTER_EN
  // Issued-word counter; fifo_pop is exactly the condition that sets valid.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      issue_count_out <= '0;
    end else if (flush_in) begin
      issue_count_out <= '0;
    end else if (fifo_pop) begin
      issue_count_out <= issue_count_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit (FIFO_DEPTH = 4).
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  fifo_count;
`ifdef FETCH_ISSUE_COUNTER_EN
  logic [15:0] issue_count;
  logic [15:0] exp_issue;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic        ivalid;
    logic [2:0]  count;
    logic        ready;
  } vec_t;

  vec_t vq[$];

  instruction_fetch_unit #(
    .FIFO_DEPTH      (4),
    .NOP_INSTRUCTION (32'h0000_0000)
  ) dut (
    .clock_in                (clk),
    .reset_in                (rst_n),
    .byte_valid_in           (byte_valid),
    .byte_data_in            (byte_data),
    .byte_ready_out          (byte_ready),
    .stall_in                (stall),
    .flush_in                (flush),
    .current_instruction_out (instr),
    .instruction_valid_out   (instr_valid),
    .fifo_count_out          (fifo_count)
`ifdef FETCH_ISSUE_COUNTER_EN
    ,
    .issue_count_out         (issue_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic v(input logic vl, input logic [7:0] d, input logic s, input logic f,
                   input logic [31:0] ins, input logic iv, input logic [2:0] c, input logic r);
    vec_t e;
    e.valid = vl; e.data = d; e.stall = s; e.flush = f;
    e.instr = ins; e.ivalid = iv; e.count = c; e.ready = r;
    vq.push_back(e);
  endtask

  task automatic drive(input logic vl, input logic [7:0] d, input logic s, input logic f);
    byte_valid = vl; byte_data = d; stall = s; flush = f;
  endtask

  initial begin
    logic [7:0] b;
    logic [2:0] c;

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    check("reset instr", instr, 32'h0);
    check("reset valid", 32'(instr_valid), 32'h0);
    check("reset count", 32'(fifo_count), 32'h0);
    check("reset ready", 32'(byte_ready), 32'h1);
`ifdef FETCH_ISSUE_COUNTER_EN
    check("reset issue_count", 32'(issue_count), 32'h0);
    exp_issue = '0;
`endif
    rst_n = 1'b1;

    // Basic word: issued one edge after byte 3, then NOP.
    v(1, 8'h03, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'h07, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'h02, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'h00, 0, 0, 32'h0, 0, 1, 1);
    v(0, 8'h00, 0, 0, 32'h0307_0200, 1, 0, 1);
    v(0, 8'h00, 0, 0, 32'h0, 0, 0, 1);

    // Fill all four slots under stall; ready drops when full.
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = {4'(w + 1), 4'(j)};
        c = (j == 3) ? 3'(w + 1) : 3'(w);
        v(1, b, 1, 0, 32'h0, 0, c, (c != 3'd4));
      end
    end
    v(1, 8'hFF, 1, 0, 32'h0, 0, 4, 0);  // offered while full: refused
    v(0, 8'h00, 0, 0, 32'h1011_1213, 1, 3, 1);
    v(0, 8'h00, 0, 0, 32'h2021_2223, 1, 2, 1);
    v(0, 8'h00, 0, 0, 32'h3031_3233, 1, 1, 1);
    v(0, 8'h00, 0, 0, 32'h4041_4243, 1, 0, 1);
    v(0, 8'h00, 0, 0, 32'h0, 0, 0, 1);

    // One buffered word held by a 3-cycle stall, issued once.
    v(1, 8'h21, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h22, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h23, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h24, 1, 0, 32'h0, 0, 1, 1);
    v(0, 8'h00, 1, 0, 32'h0, 0, 1, 1);
    v(0, 8'h00, 1, 0, 32'h0, 0, 1, 1);
    v(0, 8'h00, 1, 0, 32'h0, 0, 1, 1);
    v(0, 8'h00, 0, 0, 32'h2122_2324, 1, 0, 1);
    v(0, 8'h00, 0, 0, 32'h0, 0, 0, 1);

    // Flush discards a partial word; offered byte refused during flush.
    v(1, 8'h11, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'h22, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'h33, 0, 1, 32'h0, 0, 0, 0);
    v(1, 8'hAA, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'hBB, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'hCC, 0, 0, 32'h0, 0, 0, 1);
    v(1, 8'h06, 0, 0, 32'h0, 0, 1, 1);
    v(0, 8'h00, 0, 0, 32'hAABB_CC06, 1, 0, 1);

    // Flush beats a pending pop.
    v(1, 8'h31, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h32, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h33, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h34, 1, 0, 32'h0, 0, 1, 1);
    v(0, 8'h00, 0, 1, 32'h0, 0, 0, 0);
    v(0, 8'h00, 0, 0, 32'h0, 0, 0, 1);

    // Push and pop on the same edge keep occupancy at 1.
    v(1, 8'h41, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h42, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h43, 1, 0, 32'h0, 0, 0, 1);
    v(1, 8'h44, 1, 0, 32'h0, 0, 1, 1);
    v(1, 8'h51, 1, 0, 32'h0, 0, 1, 1);
    v(1, 8'h52, 1, 0, 32'h0, 0, 1, 1);
    v(1, 8'h53, 1, 0, 32'h0, 0, 1, 1);
    v(1, 8'h54, 0, 0, 32'h4142_4344, 1, 1, 1);
    v(0, 8'h00, 0, 0, 32'h5152_5354, 1, 0, 1);
    v(0, 8'h00, 0, 0, 32'h0, 0, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].valid, vq[i].data, vq[i].stall, vq[i].flush);
      tick();
      check($sformatf("vec%0d instr", i), instr, vq[i].instr);
      check($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vq[i].ivalid));
      check($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vq[i].count));
      check($sformatf("vec%0d ready", i), 32'(byte_ready), 32'(vq[i].ready));
`ifdef FETCH_ISSUE_COUNTER_EN
      if (vq[i].flush) exp_issue = '0;
      else if (vq[i].ivalid) exp_issue = exp_issue + 16'd1;
      check($sformatf("vec%0d issue_count", i), 32'(issue_count), 32'(exp_issue));
`endif
    end

    // Asynchronous reset mid-word with two words buffered.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(8'h70 + k), 1'b1, 1'b0);
      tick();
    end
    check("pre-reset count", 32'(fifo_count), 32'h2);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset count", 32'(fifo_count), 32'h0);
    check("async reset instr", instr, 32'h0);
    check("async reset valid", 32'(instr_valid), 32'h0);
    check("async reset ready", 32'(byte_ready), 32'h1);
`ifdef FETCH_ISSUE_COUNTER_EN
    check("async reset issue_count", 32'(issue_count), 32'h0);
`endif
    tick();
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'h12, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h34, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h56, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h78, 1'b0, 1'b0); tick();
    check("post-reset count", 32'(fifo_count), 32'h1);
    drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
    check("post-reset word", instr, 32'h1234_5678);
    check("post-reset valid", 32'(instr_valid), 32'h1);
`ifdef FETCH_ISSUE_COUNTER_EN
    check("post-reset issue_count", 32'(issue_count), 32'h1);
`endif
    tick();
    check("post-reset nop", instr, 32'h0);
    check("post-reset nop valid", 32'(instr_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream feeder for the cpu stage: accepts a byte-serial instruction stream (valid/ready), assembles bytes into 32-bit instruction words, and buffers them in a small FIFO. It issues exactly one word per clock on `current_instruction_out`, which drives the cpu's `current_instruction` input. The cpu executes every cycle, so whenever there is nothing to issue (FIFO empty, stall, or flush) the unit drives the NOP word instead.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: number of assembled words buffered; must be a power of two, ≥2.
- `NOP_INSTRUCTION`, default 32'h0000_0000: word driven when nothing is issued.

Ports:
- `clock_in`, in, 1: single clock, rising edge.
- `reset_in`, in, 1: asynchronous, active-low reset.
- `byte_valid_in`, in, 1: a byte is offered on `byte_data_in`.
- `byte_data_in`, in, 8: instruction byte.
- `byte_ready_out`, out, 1: the unit accepts the byte this cycle.
- `stall_in`, in, 1: suppresses the issue on this edge.
- `flush_in`, in, 1: synchronous discard of all buffered and partial state.
- `current_instruction_out`, out, 32: registered word presented to the cpu.
- `instruction_valid_out`, out, 1: `current_instruction_out` holds a fetched word (not NOP).
- `fifo_count_out`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Byte handshake:
  - A byte transfers on an edge where `byte_valid_in && byte_ready_out`.
  - `byte_ready_out = !fifo_full && !flush_in` (combinational).
- Assembly order is MSB first:
  - Byte 0 → [31:24] (write address).
  - Byte 1 → [23:16].
  - Byte 2 → [15:8].
  - Byte 3 → [7:0] (opcode).
- Assembler FSM states: BYTE0 → BYTE1 → BYTE2 → BYTE3 → BYTE0.
  - The state advances only on a transfer; otherwise it holds.
  - Partial bytes are kept in a 24-bit shift register.
  - The transfer taken in BYTE3 pushes {partial, byte} into the FIFO on the same edge.
- Issue, evaluated every edge in priority order:
  - `flush_in`: output ← NOP, valid ← 0.
  - Else if `!stall_in && !fifo_empty`: pop the head, output ← head, valid ← 1.
  - Else: output ← NOP, valid ← 0.
  - A stalled word is never re-driven, so it never re-executes.
- Push and pop on the same edge: allowed, and occupancy is unchanged.
  - There is no bypass: a word pushed into an empty FIFO is first poppable on the next edge.
- Full FIFO: `byte_ready_out` is 0 in every FSM state. A pop frees space and ready rises in the cycle after the pop.
- Flush:
  - Clears the FIFO (count 0) and returns the FSM to BYTE0, discarding the partial word.
  - Any offered byte is not accepted because ready is 0.
  - Flush takes priority over a simultaneous pop or push.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a separate counter, so full and empty are unambiguous.

## Timing
- Reset values:
  - `current_instruction_out` = NOP_INSTRUCTION.
  - `instruction_valid_out` = 0.
  - `fifo_count_out` = 0.
  - FSM = BYTE0.
  - `byte_ready_out` = 1.
- Reset asserted mid-word or mid-stream: all state returns to the reset values immediately (asynchronously). The partial word is lost.
- Latency:
  - Byte 3 is accepted at edge E.
  - The word is in the FIFO after E.
  - It is issued at E+1 when the FIFO was empty and there is no stall.
- Throughput: one word per 4 byte-cycles in; up to one word per cycle out.
- `fifo_count_out` is registered and reflects the state after the last edge.

## Configuration
- `FETCH_ISSUE_COUNTER_EN` defined: adds the output port `issue_count_out` [15:0].
  - Increments on every edge that sets `instruction_valid_out` to 1.
  - Wraps from 16'hFFFF to 0.
  - Cleared by reset and by `flush_in`.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - The byte-index/FSM state enum (BYTE0..BYTE3).
  - The default NOP constant.
  - The opcode constants OP_TENSOR_BULK = 8'h05 and OP_TENSOR_LOAD_IMM = 8'h06, shared with the cpu.
- Sub-module `instruction_fifo`: parameterised depth, 32-bit width, push/pop/flush, count, full/empty. It owns the pointer wrap logic.

## Test plan
- Reset release, then bytes 8'h03, 8'h07, 8'h02, 8'h00 on consecutive cycles → `current_instruction_out` = 32'h0307_0200 with valid = 1 exactly one edge after the 4th byte; NOP with valid = 0 on the following cycle.
- With `stall_in` = 1, stream 4 words (FIFO_DEPTH = 4) → count reaches 4, ready = 0. Release stall → 4 consecutive valid issues in order, ready returns to 1 after the first pop.
- Stall held for 3 cycles with 1 word buffered → output NOP/valid 0 during the stall; the word is issued once, never repeated.
- Send 2 bytes, assert `flush_in` for one cycle, then send 4 bytes 8'hAA, 8'hBB, 8'hCC, 8'h06 → the issued word is 32'hAABB_CC06 (the partial word is discarded).
- Assert `reset_in` low mid-word with 2 words buffered → outputs immediately at reset values; the next 4 bytes form a fresh word.
- With `FETCH_ISSUE_COUNTER_EN`, preload the counter near wrap through 65535 issues plus 2 → `issue_count_out` = 1.
